// File: rtl/msg_pkg.sv
// Shared types and constants for the message streamer.
// Holds ASCII codes, the FSM state type and the nibble-to-hex map.
package msg_pkg;

    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    // 0-9 -> '0'-'9', A-F -> 'A'-'F'
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

endpackage

// File: rtl/nibble_ascii.sv
// Combinational 4-bit to uppercase ASCII hex digit mapper.
// Sits in the character-select path of the streamer.
module nibble_ascii
    import msg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    assign ascii = hex_ascii(nibble);

endmodule

// File: rtl/message_streamer.sv
// Snapshots a payload on load and streams it MSB-byte-first as ASCII
// over a valid/ready byte interface, optionally hex-encoded plus LF,CR.
module message_streamer
    import msg_pkg::*;
#(
    parameter int NUM_BYTES   = 8,
    parameter int HEX_MODE    = 0,
    parameter int APPEND_CRLF = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [NUM_BYTES*8-1:0] bits_in,
    output logic                   busy,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   done
);

    localparam int PAY_CHARS = NUM_BYTES * ((HEX_MODE != 0) ? 2 : 1);
    localparam int TOTAL     = PAY_CHARS + ((APPEND_CRLF != 0) ? 2 : 0);
    localparam int IW        = $clog2(TOTAL + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(TOTAL - 1);

    state_t                 state;
    state_t                 state_next;
    logic [NUM_BYTES*8-1:0] payload;
    logic [IW-1:0]          index;

    logic                   take;
    logic                   xfer;
    logic                   last;

    logic [NUM_BYTES*8-1:0] sel_data;
    logic [IW-1:0]          sel_idx;
    int                     pos;
    int                     byte_no;
    logic [7:0]             cur_byte;
    logic [3:0]             cur_nib;
    logic [7:0]             nib_char;
    logic [7:0]             char_next;

    // Character to present after the next edge: char 0 of the live
    // input when loading, else the following char of the snapshot.
    always_comb begin
        sel_data = (state == IDLE) ? bits_in : payload;
        sel_idx  = (state == IDLE) ? '0 : index + IW'(1);
        pos      = int'(sel_idx);
        byte_no  = (HEX_MODE != 0) ? (pos / 2) : pos;
        cur_byte = '0;
        for (int b = 0; b < NUM_BYTES; b++) begin
            if (b == byte_no) begin
                cur_byte = sel_data[(NUM_BYTES-1-b)*8 +: 8];
            end
        end
        cur_nib = pos[0] ? cur_byte[3:0] : cur_byte[7:4];
    end

    nibble_ascii u_nib (
        .nibble (cur_nib),
        .ascii  (nib_char)
    );

    // Pick payload char or trailer char for the selected index.
    always_comb begin
        char_next = ASCII_CR;
        if (pos < PAY_CHARS) begin
            char_next = (HEX_MODE != 0) ? nib_char : cur_byte;
        end else if (pos == PAY_CHARS) begin
            char_next = ASCII_LF;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, load acceptance and transfer decode.
    always_comb begin
        state_next = state;
        take       = 1'b0;
        xfer       = 1'b0;
        last       = 1'b0;
        unique case (state)
            IDLE: begin
                if (load) begin
                    take       = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                xfer = tx_ready;
                last = tx_ready && (index == LAST_IDX);
                if (last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Payload snapshot, index counter, output char and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            payload <= '0;
            index   <= '0;
            tx_data <= '0;
            done    <= 1'b0;
        end else begin
            done <= last;
            if (take) begin
                payload <= bits_in;
                index   <= '0;
                tx_data <= char_next;
            end else if (xfer && !last) begin
                index   <= index + IW'(1);
                tx_data <= char_next;
            end else if (last) begin
                index   <= '0;
            end
        end
    end

    assign busy     = (state == SEND);
    assign tx_valid = (state == SEND);

endmodule

// File: tb/tb_message_streamer.sv
// Directed scoreboard bench for message_streamer across three
// parameter sets: raw+CRLF, hex+CRLF, and single raw byte.
module tb_message_streamer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          sel = 0;
    logic        load = 1'b0;
    logic        ready = 1'b0;
    logic [63:0] bits_a = '0;
    logic [15:0] bits_b = '0;
    logic [7:0]  bits_c = '0;

    logic        load_a, load_b, load_c;
    logic        busy_a, busy_b, busy_c;
    logic        valid_a, valid_b, valid_c;
    logic        done_a, done_b, done_c;
    logic [7:0]  data_a, data_b, data_c;

    logic        obs_busy, obs_valid, obs_done;
    logic [7:0]  obs_data;

    logic [7:0]  sb[$];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    assign load_a = load && (sel == 0);
    assign load_b = load && (sel == 1);
    assign load_c = load && (sel == 2);

    message_streamer u_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load_a),
        .bits_in  (bits_a),
        .busy     (busy_a),
        .tx_data  (data_a),
        .tx_valid (valid_a),
        .tx_ready (ready),
        .done     (done_a)
    );

    message_streamer #(
        .NUM_BYTES   (2),
        .HEX_MODE    (1),
        .APPEND_CRLF (1)
    ) u_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load_b),
        .bits_in  (bits_b),
        .busy     (busy_b),
        .tx_data  (data_b),
        .tx_valid (valid_b),
        .tx_ready (ready),
        .done     (done_b)
    );

    message_streamer #(
        .NUM_BYTES   (1),
        .HEX_MODE    (0),
        .APPEND_CRLF (0)
    ) u_c (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load_c),
        .bits_in  (bits_c),
        .busy     (busy_c),
        .tx_data  (data_c),
        .tx_valid (valid_c),
        .tx_ready (ready),
        .done     (done_c)
    );

    always_comb begin
        obs_busy  = busy_a;
        obs_valid = valid_a;
        obs_done  = done_a;
        obs_data  = data_a;
        case (sel)
            1: begin
                obs_busy  = busy_b;
                obs_valid = valid_b;
                obs_done  = done_b;
                obs_data  = data_b;
            end
            2: begin
                obs_busy  = busy_c;
                obs_valid = valid_c;
                obs_done  = done_c;
                obs_data  = data_c;
            end
            default: ;
        endcase
    end

    function automatic logic [7:0] hexc(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        return 8'h41 + {4'h0, n} - 8'd10;
    endfunction

    task automatic push_msg(input logic [255:0] data, input int nb,
                            input bit hex, input bit crlf);
        logic [7:0] b;
        for (int i = 0; i < nb; i++) begin
            b = data[(nb-1-i)*8 +: 8];
            if (hex) begin
                sb.push_back(hexc(b[7:4]));
                sb.push_back(hexc(b[3:0]));
            end else begin
                sb.push_back(b);
            end
        end
        if (crlf) begin
            sb.push_back(8'h0A);
            sb.push_back(8'h0D);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Caller drives load=1 at a negedge, then calls this.
    task automatic run_msg(input string tag, input int total,
                           input int stall_at, input int stall_len,
                           input int mid_load, input bit final_load,
                           input bit poke_bits);
        int         xfers;
        int         stalls;
        int         cyc;
        bit         got_done;
        logic [7:0] held;
        logic [7:0] lastc;
        logic [7:0] exp;
        xfers    = 0;
        stalls   = 0;
        got_done = 0;
        held     = '0;
        lastc    = '0;
        @(negedge clk);
        load = 1'b0;
        check({tag, ":start_busy"}, 32'(obs_busy), 32'd1);
        check({tag, ":start_valid"}, 32'(obs_valid), 32'd1);
        if (poke_bits) begin
            bits_a = ~bits_a;
            bits_b = ~bits_b;
            bits_c = ~bits_c;
        end
        for (cyc = 1; cyc <= total + stall_len + 5; cyc++) begin
            if (cyc > 1) @(negedge clk);
            load = 1'b0;
            if (obs_done) begin
                got_done = 1;
                break;
            end
            ready = !(xfers == stall_at && stalls < stall_len);
            if (!ready) begin
                if (stalls == 0) begin
                    held = obs_data;
                end else begin
                    check({tag, ":stall_data"}, 32'(obs_data), 32'(held));
                    check({tag, ":stall_valid"}, 32'(obs_valid), 32'd1);
                end
                stalls++;
            end
            if (ready && xfers == mid_load) load = 1'b1;
            if (ready && final_load && xfers == total - 1) load = 1'b1;
            if (obs_valid && ready) begin
                checks++;
                assert (sb.size() != 0) else begin
                    failures++;
                    $error("FAIL %s:extra observed=%0d expected=%0d",
                           tag, xfers + 1, total);
                end
                if (sb.size() != 0) begin
                    exp = sb.pop_front();
                    check({tag, ":char"}, 32'(obs_data), 32'(exp));
                    lastc = exp;
                end
                xfers++;
            end else if (!obs_valid) begin
                check({tag, ":valid_gap"}, 32'(obs_valid), 32'd1);
            end
        end
        check({tag, ":done_seen"}, 32'(got_done), 32'd1);
        if (got_done) begin
            check({tag, ":latency"}, 32'(cyc), 32'(total + 1 + stall_len));
            check({tag, ":done_busy"}, 32'(obs_busy), 32'd0);
            check({tag, ":done_valid"}, 32'(obs_valid), 32'd0);
            check({tag, ":hold_data"}, 32'(obs_data), 32'(lastc));
            check({tag, ":xfers"}, 32'(xfers), 32'(total));
            check({tag, ":sb_empty"}, 32'(sb.size()), 32'd0);
            ready = 1'b1;
            @(negedge clk);
            check({tag, ":done_pulse"}, 32'(obs_done), 32'd0);
            check({tag, ":no_restart"}, 32'(obs_busy), 32'd0);
            check({tag, ":idle_valid"}, 32'(obs_valid), 32'd0);
        end
    endtask

    initial begin
        // Reset state of all instances
        repeat (2) @(negedge clk);
        check("rst:busy_a", 32'(busy_a), 32'd0);
        check("rst:valid_a", 32'(valid_a), 32'd0);
        check("rst:data_a", 32'(data_a), 32'd0);
        check("rst:done_a", 32'(done_a), 32'd0);
        check("rst:valid_b", 32'(valid_b), 32'd0);
        check("rst:data_c", 32'(data_c), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Raw default message
        sel    = 0;
        bits_a = "HELLO!!!";
        load   = 1'b1;
        ready  = 1'b1;
        push_msg(256'(bits_a), 8, 0, 1);
        run_msg("raw", 10, -1, 0, -1, 0, 0);

        // Hex mode, two bytes
        sel    = 1;
        bits_b = 16'hA50F;
        load   = 1'b1;
        push_msg(256'(bits_b), 2, 1, 1);
        run_msg("hex", 6, -1, 0, -1, 0, 0);

        // Backpressure for 3 cycles mid-message
        sel    = 0;
        bits_a = 64'h0123_4567_89AB_CDEF;
        load   = 1'b1;
        push_msg(256'(bits_a), 8, 0, 1);
        run_msg("bp", 10, 4, 3, -1, 0, 0);

        // Snapshot + ignored loads mid-message and on final transfer
        sel    = 0;
        bits_a = "STREAMER";
        load   = 1'b1;
        push_msg(256'(bits_a), 8, 0, 1);
        run_msg("snap", 10, -1, 0, 5, 1, 1);

        // Asynchronous reset mid-message
        sel    = 0;
        bits_a = "RESET_ME";
        load   = 1'b1;
        ready  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst:busy", 32'(busy_a), 32'd0);
        check("arst:valid", 32'(valid_a), 32'd0);
        check("arst:done", 32'(done_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst:idle", 32'(busy_a), 32'd0);
        bits_a = "FRESH_GO";
        load   = 1'b1;
        push_msg(256'(bits_a), 8, 0, 1);
        run_msg("rst", 10, -1, 0, -1, 0, 0);

        // Single byte, no trailer
        sel    = 2;
        bits_c = 8'h7E;
        load   = 1'b1;
        push_msg(256'(bits_c), 1, 0, 0);
        run_msg("tiny", 1, -1, 0, -1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
